player_ctrl: RTL and testbench
==============================

// Module: player_ctrl
// PURPOSE
//   Parametrised player-ship controller for the shooter playfield. Moves the player by a
//   configurable step from a 4-bit direction bitmap, with diagonals and a slow "focus" speed.
//   Clamps the position to a parametrised playfield rectangle.
//   Runs a hit/death/respawn/invulnerability state machine with a lives counter, and feeds the
//   renderer (posx/posy) and the game-flow logic (gameover).
// PARAMETERS
//   XW         10   position width, bits
//   X_MIN      0    leftmost legal x
//   X_MAX      440  rightmost legal x
//   Y_MIN      0    topmost legal y
//   Y_MAX      480  bottom legal y
//   SPAWN_X    220  spawn/respawn x
//   SPAWN_Y    360  spawn/respawn y
//   SPD_FAST   2    step per clk22 edge, normal speed
//   SPD_SLOW   1    step per clk22 edge while focus=1
//   LIVES      3    initial lives (>=1)
//   DEATH_CYC  32   cycles spent in DYING (>=1)
//   INVULN_CYC 64   cycles spent in INVULN (>=1)
//   LW derived: $clog2(LIVES+1)
// PORTS
//   clk22     in   1   game tick clock
//   rst       in   1   synchronous reset, active-high
//   btn       in   4   [0]=up [1]=down [2]=left [3]=right, level, any combination
//   focus     in   1   1 = use SPD_SLOW
//   hit       in   1   collision pulse from bullet logic
//   freeze    in   1   pause: all state, timers and position hold
//   posx      out  XW  player x
//   posy      out  XW  player y
//   state     out  2   0=ALIVE 1=DYING 2=INVULN 3=OVER
//   invuln    out  1   1 while state==INVULN (renderer blinks sprite)
//   lives     out  LW  remaining lives
//   gameover  out  1   1 while state==OVER
// BEHAVIOUR
//   - Clocking: one clock (clk22). Reset is synchronous and active-high. All outputs are registered.
//   - Reset values: posx=SPAWN_X, posy=SPAWN_Y, state=ALIVE, lives=LIVES, invuln=0, gameover=0,
//     timer=0. rst wins over every other input in every state, including mid-DYING and OVER.
//   - Movement (ALIVE or INVULN, freeze=0):
//     - dx = right-left, dy = down-up. Opposite buttons cancel to 0.
//     - step = focus ? SPD_SLOW : SPD_FAST. Diagonals apply the full step on both axes.
//     - The sum is computed signed in XW+2 bits, then clamped to [X_MIN,X_MAX] / [Y_MIN,Y_MAX].
//     - No wrap-around: 0 - step gives X_MIN, never 1023.
//     - Latency: 1 cycle (btn sampled at edge n appears on posx/posy after edge n).
//   - ALIVE:
//     - hit=1 and freeze=0 -> DYING. lives <= lives-1. timer <= DEATH_CYC-1.
//     - The position does not update on the hit cycle; hit wins over movement.
//   - DYING:
//     - Position frozen; btn ignored. timer decrements each cycle.
//     - At timer==0: if lives==0 -> OVER. Otherwise posx/posy <= SPAWN, state -> INVULN,
//       timer <= INVULN_CYC-1.
//   - INVULN:
//     - Movement allowed. hit ignored. timer decrements; at timer==0 -> ALIVE.
//   - OVER:
//     - Sticky until rst. Position holds last value. btn and hit ignored. lives==0.
//   - Other rules:
//     - freeze=1: nothing changes, including timers. A hit arriving while freeze=1 is
//       dropped, not queued.
//     - A hit in DYING, INVULN or OVER is dropped. lives never underflows.
//     - invuln and gameover are decoded from the next-state register and align with state.
// STRUCTURE
//   - Shared package player_pkg:
//     - state encoding localparams ST_ALIVE/ST_DYING/ST_INVULN/ST_OVER
//     - btn bit indices BTN_UP/BTN_DN/BTN_LT/BTN_RT
//   - Sub-module axis_step, instanced twice (x, y):
//     - params W, MIN, MAX
//     - inputs pos, neg, posdir, step, en; output next
//     - purely combinational signed add + clamp
//   - Top level holds the FSM, timer (width from max(DEATH_CYC,INVULN_CYC)), lives and the
//     position registers.
// TESTING
//   1. Reset, then btn=4'b1000 focus=0 for 10 cycles -> posx=240, posy=360. state=0.
//   2. posx driven to 1, btn=left focus=0 -> posx=0 next cycle and stays 0.
//      posy at 480 with btn=down -> stays 480.
//   3. btn=4'b1001 (up+right), focus=1, 5 cycles -> posx=225, posy=355.
//      btn=4'b1100 (left+right) -> posx unchanged.
//   4. hit in ALIVE with btn=right held:
//      - posx unchanged that cycle, state=1, lives=2.
//      - 32 cycles later: posx=220, posy=360, state=2, invuln=1.
//      - 64 cycles later: state=0.
//   5. A hit in DYING, another in INVULN, and a hit with freeze=1 -> lives unchanged.
//      freeze for 20 cycles mid-DYING -> DYING lasts 52 cycles total.
//   6. Three accepted hits -> after the third DYING: state=3, gameover=1, lives=0.
//      Further btn/hit -> no change. rst -> all reset values.
//      Also: rst asserted mid-DYING -> reset values on the next edge.

Source files
------------

// File: rtl/player_pkg.sv
// Shared definitions for the player-ship controller: state encoding,
// button bit positions and a small elaboration-time helper.
package player_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_DYING  = 2'd1,
    ST_INVULN = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  localparam int BTN_UP = 0;
  localparam int BTN_DN = 1;
  localparam int BTN_LT = 2;
  localparam int BTN_RT = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/player_ctrl_axis_step.sv
// One axis of player motion: signed add of +/-step, then clamp into [MIN,MAX].
// The sum is formed two bits wider than the position so underflow never wraps.
module axis_step #(
  parameter int W   = 10,
  parameter int MIN = 0,
  parameter int MAX = 440
) (
  input  logic [W-1:0] pos,
  input  logic         neg,
  input  logic         posdir,
  input  logic [W-1:0] step,
  input  logic         en,
  output logic [W-1:0] next
);

  localparam logic signed [W+1:0] MIN_S = (W+2)'(MIN);
  localparam logic signed [W+1:0] MAX_S = (W+2)'(MAX);

  logic signed [W+1:0] delta_s;
  logic signed [W+1:0] sum_s;

  // Signed delta from the button pair, then clamp the candidate position
  always_comb begin
    delta_s = {(W+2){1'b0}};
    if (posdir && !neg) begin
      delta_s = $signed({2'b00, step});
    end else if (neg && !posdir) begin
      delta_s = -$signed({2'b00, step});
    end else begin
      delta_s = {(W+2){1'b0}};
    end

    sum_s = $signed({2'b00, pos}) + delta_s;

    if (!en) begin
      next = pos;
    end else if (sum_s < MIN_S) begin
      next = W'(MIN);
    end else if (sum_s > MAX_S) begin
      next = W'(MAX);
    end else begin
      next = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Player-ship controller: clamped movement, hit/death/respawn/invulnerability
// state machine and lives counter. All outputs come straight from flops.
module player_ctrl
  import player_pkg::*;
#(
  parameter int XW         = 10,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 440,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 480,
  parameter int SPAWN_X    = 220,
  parameter int SPAWN_Y    = 360,
  parameter int SPD_FAST   = 2,
  parameter int SPD_SLOW   = 1,
  parameter int LIVES      = 3,
  parameter int DEATH_CYC  = 32,
  parameter int INVULN_CYC = 64,
  localparam int LW        = $clog2(LIVES + 1)
) (
  input  logic          clk22,
  input  logic          rst,
  input  logic [3:0]    btn,
  input  logic          focus,
  input  logic          hit,
  input  logic          freeze,
  output logic [XW-1:0] posx,
  output logic [XW-1:0] posy,
  output logic [1:0]    state,
  output logic          invuln,
  output logic [LW-1:0] lives,
  output logic          gameover
);

  localparam int TMAX = max_int(DEATH_CYC, INVULN_CYC);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_e        state_q, state_d;
  logic [XW-1:0] posx_q, posx_d;
  logic [XW-1:0] posy_q, posy_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          invuln_q, invuln_d;
  logic          gameover_q, gameover_d;

  logic [XW-1:0] step_s;
  logic          move_en_s;
  logic [XW-1:0] nx_s, ny_s;

  // Movement is allowed in ALIVE (unless this cycle's hit is taken) and INVULN
  always_comb begin
    step_s    = focus ? XW'(SPD_SLOW) : XW'(SPD_FAST);
    move_en_s = 1'b0;
    if (freeze) begin
      move_en_s = 1'b0;
    end else if (state_q == ST_ALIVE) begin
      move_en_s = !hit;
    end else if (state_q == ST_INVULN) begin
      move_en_s = 1'b1;
    end else begin
      move_en_s = 1'b0;
    end
  end

  axis_step #(.W(XW), .MIN(X_MIN), .MAX(X_MAX)) u_axis_x (
    .pos    (posx_q),
    .neg    (btn[BTN_LT]),
    .posdir (btn[BTN_RT]),
    .step   (step_s),
    .en     (move_en_s),
    .next   (nx_s)
  );

  axis_step #(.W(XW), .MIN(Y_MIN), .MAX(Y_MAX)) u_axis_y (
    .pos    (posy_q),
    .neg    (btn[BTN_UP]),
    .posdir (btn[BTN_DN]),
    .step   (step_s),
    .en     (move_en_s),
    .next   (ny_s)
  );

  // Next-state, timer, lives and position; freeze holds everything
  always_comb begin
    state_d = state_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    lives_d = lives_q;
    timer_d = timer_q;

    if (freeze) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (hit) begin
            state_d = ST_DYING;
            lives_d = (lives_q != {LW{1'b0}}) ? lives_q - LW'(1) : {LW{1'b0}};
            timer_d = TW'(DEATH_CYC - 1);
          end else begin
            posx_d = nx_s;
            posy_d = ny_s;
          end
        end
        ST_DYING: begin
          if (timer_q != {TW{1'b0}}) begin
            timer_d = timer_q - TW'(1);
          end else if (lives_q == {LW{1'b0}}) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_INVULN;
            posx_d  = XW'(SPAWN_X);
            posy_d  = XW'(SPAWN_Y);
            timer_d = TW'(INVULN_CYC - 1);
          end
        end
        ST_INVULN: begin
          posx_d = nx_s;
          posy_d = ny_s;
          if (timer_q != {TW{1'b0}}) begin
            timer_d = timer_q - TW'(1);
          end else begin
            state_d = ST_ALIVE;
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_OVER;
        end
      endcase
    end

    // Flags track the state being entered so they line up with state_q
    invuln_d   = (state_d == ST_INVULN);
    gameover_d = (state_d == ST_OVER);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk22) begin
    if (rst) begin
      state_q    <= ST_ALIVE;
      posx_q     <= XW'(SPAWN_X);
      posy_q     <= XW'(SPAWN_Y);
      lives_q    <= LW'(LIVES);
      timer_q    <= {TW{1'b0}};
      invuln_q   <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      posx_q     <= posx_d;
      posy_q     <= posy_d;
      lives_q    <= lives_d;
      timer_q    <= timer_d;
      invuln_q   <= invuln_d;
      gameover_q <= gameover_d;
    end
  end

  assign posx     = posx_q;
  assign posy     = posy_q;
  assign state    = state_q;
  assign invuln   = invuln_q;
  assign lives    = lives_q;
  assign gameover = gameover_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_player_ctrl;

  logic       clk22 = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       focus = 1'b0;
  logic       hit = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] posx, posy;
  logic [1:0] state;
  logic       invuln;
  logic [1:0] lives;
  logic       gameover;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // model: state 0 alive, 1 dying, 2 invuln, 3 over; m_left = cycles still to spend in phase
  int m_x, m_y, m_state, m_lives, m_left;

  player_ctrl dut (
    .clk22(clk22), .rst(rst), .btn(btn), .focus(focus), .hit(hit), .freeze(freeze),
    .posx(posx), .posy(posy), .state(state), .invuln(invuln), .lives(lives),
    .gameover(gameover)
  );

  always #5 clk22 = ~clk22;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_move();
    int s, dx, dy;
    s  = focus ? 1 : 2;
    dx = int'(btn[3]) - int'(btn[2]);
    dy = int'(btn[1]) - int'(btn[0]);
    m_x = clampi(m_x + dx * s, 0, 440);
    m_y = clampi(m_y + dy * s, 0, 480);
  endtask

  task automatic model_step();
    if (rst) begin
      m_x = 220; m_y = 360; m_state = 0; m_lives = 3; m_left = 0;
    end else if (!freeze) begin
      if (m_state == 0) begin
        if (hit) begin
          m_state = 1; m_lives = m_lives - 1; m_left = 32;
        end else begin
          model_move();
        end
      end else if (m_state == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_lives == 0) begin
            m_state = 3;
          end else begin
            m_state = 2; m_x = 220; m_y = 360; m_left = 64;
          end
        end
      end else if (m_state == 2) begin
        model_move();
        m_left = m_left - 1;
        if (m_left == 0) m_state = 0;
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk22);
      #1;
      model_step();
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk22) begin
    if (cmp_en) begin
      chk("m_posx", int'(posx), m_x);
      chk("m_posy", int'(posy), m_y);
      chk("m_state", int'(state), m_state);
      chk("m_lives", int'(lives), m_lives);
      chk("m_invuln", int'(invuln), (m_state == 2) ? 1 : 0);
      chk("m_gameover", int'(gameover), (m_state == 3) ? 1 : 0);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_posx"}, int'(posx), 220);
    chk({tag, "_posy"}, int'(posy), 360);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_lives"}, int'(lives), 3);
    chk({tag, "_invuln"}, int'(invuln), 0);
    chk({tag, "_gameover"}, int'(gameover), 0);
  endtask

  initial begin
    rst = 1'b1;
    cyc(2);
    cmp_en = 1'b1;
    rst = 1'b0;
    chk_reset_vals("reset");

    // 1: move right at fast speed
    btn = 4'b1000; focus = 1'b0;
    cyc(10);
    chk("t1_posx", int'(posx), 240);
    chk("t1_posy", int'(posy), 360);
    chk("t1_state", int'(state), 0);

    // 2: clamp at left and bottom edges
    btn = 4'b0100;
    cyc(125);
    chk("t2_left_edge", int'(posx), 0);
    btn = 4'b1000; focus = 1'b1;
    cyc(1);
    chk("t2_posx_one", int'(posx), 1);
    btn = 4'b0100; focus = 1'b0;
    cyc(1);
    chk("t2_no_wrap", int'(posx), 0);
    cyc(1);
    chk("t2_stay_zero", int'(posx), 0);
    btn = 4'b0010;
    cyc(65);
    chk("t2_bottom", int'(posy), 480);

    // 3: diagonal at focus speed, then cancelled horizontal
    btn = 4'b0000; rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    btn = 4'b1001; focus = 1'b1;
    cyc(5);
    chk("t3_diag_x", int'(posx), 225);
    chk("t3_diag_y", int'(posy), 355);
    btn = 4'b1100; focus = 1'b0;
    cyc(1);
    chk("t3_cancel_x", int'(posx), 225);

    // 4: hit beats movement, then death and respawn timing
    btn = 4'b1000; hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    chk("t4_hit_posx", int'(posx), 225);
    chk("t4_hit_state", int'(state), 1);
    chk("t4_hit_lives", int'(lives), 2);
    cyc(31);
    chk("t4_still_dying", int'(state), 1);
    chk("t4_frozen_x", int'(posx), 225);
    cyc(1);
    chk("t4_spawn_x", int'(posx), 220);
    chk("t4_spawn_y", int'(posy), 360);
    chk("t4_invuln_state", int'(state), 2);
    chk("t4_invuln_flag", int'(invuln), 1);
    btn = 4'b0000;
    cyc(63);
    chk("t4_invuln_end", int'(state), 2);
    cyc(1);
    chk("t4_alive", int'(state), 0);

    // 5: dropped hits and freeze stretching DYING to 52 cycles
    hit = 1'b1;
    cyc(1);
    chk("t5_lives_after_hit", int'(lives), 1);
    cyc(9);
    freeze = 1'b1;
    cyc(20);
    freeze = 1'b0; hit = 1'b0;
    cyc(22);
    chk("t5_dying_51", int'(state), 1);
    cyc(1);
    chk("t5_dying_done", int'(state), 2);
    chk("t5_lives_kept", int'(lives), 1);
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    chk("t5_invuln_hit", int'(lives), 1);
    cyc(63);
    chk("t5_back_alive", int'(state), 0);
    freeze = 1'b1; hit = 1'b1;
    cyc(1);
    freeze = 1'b0; hit = 1'b0;
    cyc(1);
    chk("t5_freeze_hit_state", int'(state), 0);
    chk("t5_freeze_hit_lives", int'(lives), 1);

    // 6: last life lost, sticky OVER, reset from OVER and from DYING
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    cyc(32);
    chk("t6_over_state", int'(state), 3);
    chk("t6_gameover", int'(gameover), 1);
    chk("t6_lives_zero", int'(lives), 0);
    for (int i = 0; i < 20; i++) begin
      btn = 4'($urandom_range(0, 15));
      hit = 1'($urandom_range(0, 1));
      cyc(1);
    end
    hit = 1'b0; btn = 4'b0000;
    chk("t6_over_sticky", int'(state), 3);
    chk("t6_over_posx", int'(posx), 220);
    chk("t6_over_lives", int'(lives), 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_reset_vals("rst_over");
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    cyc(5);
    chk("t6_mid_dying", int'(state), 1);
    rst = 1'b1; hit = 1'b1;
    cyc(1);
    rst = 1'b0; hit = 1'b0;
    chk_reset_vals("rst_dying");

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      btn    = 4'($urandom_range(0, 15));
      focus  = 1'($urandom_range(0, 1));
      hit    = ($urandom_range(0, 39) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    rst = 1'b0; hit = 1'b0; freeze = 1'b0;
    cyc(2);
    @(posedge clk22);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
